// File: rtl/bcd_updown_counter_if.sv
// rtl/bcd_updown_counter_if.sv - request/result bundle for bcd_updown_counter
// Load signals exist only when BCD_COUNTER_LOAD_EN is defined.
interface bcd_updown_counter_if #(
   parameter int COUNTER_BITWIDTH = 24
);
   logic                        enable;
   logic                        direction;
   logic                        ready;
   logic [COUNTER_BITWIDTH-1:0] countValue;
   logic                        wrap;
`ifdef BCD_COUNTER_LOAD_EN
   logic                        load;
   logic [COUNTER_BITWIDTH-1:0] loadValue;
   logic                        loadError;

   modport master (output enable, direction, load, loadValue,
                   input  ready, countValue, wrap, loadError);
   modport slave  (input  enable, direction, load, loadValue,
                   output ready, countValue, wrap, loadError);
`else
   modport master (output enable, direction,
                   input  ready, countValue, wrap);
   modport slave  (input  enable, direction,
                   output ready, countValue, wrap);
`endif
endinterface

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - digit-serial multi-digit BCD up/down counter, wrap or saturate
// Optional validated parallel load enabled by BCD_COUNTER_LOAD_EN.
module bcd_updown_counter #(
   parameter int COUNTER_DIGITS       = 6,
   parameter int COUNTER_BITWIDTH     = COUNTER_DIGITS*4,
   parameter int DIGIT_INDEX_BITWIDTH = $clog2(COUNTER_DIGITS+1),
   parameter bit SATURATE             = 1'b0
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   bcd_updown_counter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, READY, STEP, UPDATE} state_t;

   localparam logic [DIGIT_INDEX_BITWIDTH-1:0] LAST_DIGIT =
      DIGIT_INDEX_BITWIDTH'(COUNTER_DIGITS-1);

   state_t                          state_q, state_d;
   logic [COUNTER_BITWIDTH-1:0]     work_q, work_d;
   logic [COUNTER_BITWIDTH-1:0]     count_q, count_d;
   logic [DIGIT_INDEX_BITWIDTH-1:0] digit_q, digit_d;
   logic                            dir_q, dir_d;
   logic                            wrap_q, wrap_d;
   logic [3:0]                      cur_digit;
   logic [3:0]                      new_digit;
   logic                            carry;
   logic                            request;
`ifdef BCD_COUNTER_LOAD_EN
   logic                            load_err_q, load_err_d;
   logic                            load_bad;
`endif

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      count_d   = count_q;
      digit_d   = digit_q;
      dir_d     = dir_q;
      wrap_d    = 1'b0;
      cur_digit = 4'd0;
`ifdef BCD_COUNTER_LOAD_EN
      load_err_d = 1'b0;
      load_bad   = 1'b0;
      for (int i = 0; i < COUNTER_DIGITS; i++) begin
         if (bus.loadValue[i*4 +: 4] > 4'd9) load_bad = 1'b1;
      end
      request = bus.enable | bus.load;
`else
      request = bus.enable;
`endif

      for (int i = 0; i < COUNTER_DIGITS; i++) begin
         if (digit_q == DIGIT_INDEX_BITWIDTH'(i)) cur_digit = work_q[i*4 +: 4];
      end

      // A digit is only visited while carry/borrow is pending, so the incoming carry is always 1.
      if (dir_q) begin
         carry     = (cur_digit == 4'd9);
         new_digit = carry ? 4'd0 : cur_digit + 4'd1;
      end else begin
         carry     = (cur_digit == 4'd0);
         new_digit = carry ? 4'd9 : cur_digit - 4'd1;
      end

      case (state_q)
         IDLE: begin
            if (!request) state_d = READY;
         end
         READY: begin
`ifdef BCD_COUNTER_LOAD_EN
            if (bus.load) begin
               if (load_bad) begin
                  load_err_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  work_d  = bus.loadValue;
                  state_d = UPDATE;
               end
            end else
`endif
            if (bus.enable) begin
               dir_d   = bus.direction;
               digit_d = '0;
               work_d  = count_q;
               state_d = STEP;
            end
         end
         STEP: begin
            for (int i = 0; i < COUNTER_DIGITS; i++) begin
               if (digit_q == DIGIT_INDEX_BITWIDTH'(i)) work_d[i*4 +: 4] = new_digit;
            end
            if (!carry) begin
               state_d = UPDATE;
            end else if (digit_q == LAST_DIGIT) begin
               // count_q still holds the pre-step value, so saturation simply restores it.
               wrap_d  = 1'b1;
               state_d = UPDATE;
               if (SATURATE) work_d = count_q;
            end else begin
               digit_d = digit_q + 1'b1;
            end
         end
         UPDATE: begin
            count_d = work_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         work_q     <= '0;
         count_q    <= '0;
         digit_q    <= '0;
         dir_q      <= 1'b0;
         wrap_q     <= 1'b0;
`ifdef BCD_COUNTER_LOAD_EN
         load_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         work_q     <= work_d;
         count_q    <= count_d;
         digit_q    <= digit_d;
         dir_q      <= dir_d;
         wrap_q     <= wrap_d;
`ifdef BCD_COUNTER_LOAD_EN
         load_err_q <= load_err_d;
`endif
      end
   end

   assign bus.ready      = (state_q == READY);
   assign bus.countValue = count_q;
   assign bus.wrap       = wrap_q;
`ifdef BCD_COUNTER_LOAD_EN
   assign bus.loadError  = load_err_q;
`endif

endmodule
